// File: rtl/inst_queue.sv
// Dual-issue instruction buffer between fetch and id1/issue: up to two pushes and two pops per cycle.
// Optional feature macro: INST_QUEUE_BYPASS_EN (empty-queue push-to-read combinational bypass).
module inst_queue #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       w_ena1,
    input  logic                       w_ena2,
    input  logic [31:0]                w_pc1,
    input  logic [31:0]                w_pc2,
    input  logic [31:0]                w_inst1,
    input  logic [31:0]                w_inst2,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       r_ena1,
    input  logic                       r_ena2,
    output logic                       r_valid1,
    output logic                       r_valid2,
    output logic [31:0]                r_pc1,
    output logic [31:0]                r_pc2,
    output logic [31:0]                r_inst1,
    output logic [31:0]                r_inst2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_p1_s, tail_p1_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             full_s;
    logic [1:0]       nw_s, np_s;
    logic             we1_s, we2_s;

    assign full_s    = (count_q > CNT_W'(DEPTH - 2));
    assign full      = full_s;
    assign empty     = (count_q == CNT_W'(0));
    assign count     = count_q;
    assign head_p1_s = head_q + PTR_W'(1);
    assign tail_p1_s = tail_q + PTR_W'(1);

    // Read-side valids and data; data is forced to zero whenever its valid is low.
    always_comb begin
        r_valid1 = (count_q >= CNT_W'(1));
        r_valid2 = (count_q >= CNT_W'(2));
        r_pc1    = r_valid1 ? pc_mem_q[head_q]      : 32'h0000_0000;
        r_inst1  = r_valid1 ? inst_mem_q[head_q]    : 32'h0000_0000;
        r_pc2    = r_valid2 ? pc_mem_q[head_p1_s]   : 32'h0000_0000;
        r_inst2  = r_valid2 ? inst_mem_q[head_p1_s] : 32'h0000_0000;
`ifdef INST_QUEUE_BYPASS_EN
        // Empty queue: present the incoming pushes directly to issue.
        if ((count_q == CNT_W'(0)) && !flush) begin
            r_valid1 = w_ena1;
            r_valid2 = w_ena1 & w_ena2;
            r_pc1    = r_valid1 ? w_pc1   : 32'h0000_0000;
            r_inst1  = r_valid1 ? w_inst1 : 32'h0000_0000;
            r_pc2    = r_valid2 ? w_pc2   : 32'h0000_0000;
            r_inst2  = r_valid2 ? w_inst2 : 32'h0000_0000;
        end else begin
            r_valid1 = r_valid1;
            r_valid2 = r_valid2;
        end
`endif
    end

    // Accepted push/pop counts and next pointer/occupancy state.
    always_comb begin
        nw_s    = 2'd0;
        np_s    = 2'd0;
        we1_s   = 1'b0;
        we2_s   = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (full_s) begin
            nw_s = 2'd0;
        end else begin
            nw_s = {1'b0, w_ena1} + {1'b0, w_ena1 & w_ena2};
        end
        if (stall) begin
            np_s = 2'd0;
        end else begin
            np_s = {1'b0, r_ena1 & r_valid1} + {1'b0, r_ena1 & r_ena2 & r_valid2};
        end
        // A popped bypass entry is still written, but head skips past it, so it is never seen again.
        if (flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            we1_s   = (nw_s != 2'd0);
            we2_s   = (nw_s == 2'd2);
            head_d  = head_q + PTR_W'(np_s);
            tail_d  = tail_q + PTR_W'(nw_s);
            count_d = count_q + CNT_W'(nw_s) - CNT_W'(np_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we1_s) begin
            pc_mem_q[tail_q]   <= w_pc1;
            inst_mem_q[tail_q] <= w_inst1;
        end
        if (we2_s) begin
            pc_mem_q[tail_p1_s]   <= w_pc2;
            inst_mem_q[tail_p1_s] <= w_inst2;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed steps with a scoreboard queue of expected {pc, inst} entries.
module tb_inst_queue;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, stall = 1'b0;
    logic        w_ena1 = 1'b0, w_ena2 = 1'b0;
    logic [31:0] w_pc1 = 32'h0, w_pc2 = 32'h0, w_inst1 = 32'h0, w_inst2 = 32'h0;
    logic        r_ena1 = 1'b0, r_ena2 = 1'b0;
    logic        full, empty, r_valid1, r_valid2;
    logic [4:0]  count;
    logic [31:0] r_pc1, r_pc2, r_inst1, r_inst2;

    int   tests = 0;
    int   fails = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .w_ena1(w_ena1), .w_ena2(w_ena2),
        .w_pc1(w_pc1), .w_pc2(w_pc2), .w_inst1(w_inst1), .w_inst2(w_inst2),
        .full(full), .empty(empty), .count(count),
        .r_ena1(r_ena1), .r_ena2(r_ena2),
        .r_valid1(r_valid1), .r_valid2(r_valid2),
        .r_pc1(r_pc1), .r_pc2(r_pc2), .r_inst1(r_inst1), .r_inst2(r_inst2)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check the pre-edge outputs against the scoreboard, then update it at the edge.
    task automatic step(input logic we1, input logic we2, input logic [31:0] p1, input logic [31:0] p2,
                        input logic re1, input logic re2, input logic st, input logic fl);
        logic ev1, ev2, byp;
        ent_t e1, e2;
        int   nw, np;
        w_ena1 = we1; w_ena2 = we2;
        w_pc1 = p1; w_pc2 = p2; w_inst1 = inst_of(p1); w_inst2 = inst_of(p2);
        r_ena1 = re1; r_ena2 = re2; stall = st; flush = fl;
        #2;
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && !fl;
`endif
        e1 = '0;
        e2 = '0;
        if (byp) begin
            ev1 = we1;
            ev2 = we1 & we2;
            if (ev1) e1 = {p1, inst_of(p1)};
            if (ev2) e2 = {p2, inst_of(p2)};
        end else begin
            ev1 = (sb.size() >= 1);
            ev2 = (sb.size() >= 2);
            if (ev1) e1 = sb[0];
            if (ev2) e2 = sb[1];
        end
        chk("r_valid1", 64'(r_valid1), 64'(ev1));
        chk("r_valid2", 64'(r_valid2), 64'(ev2));
        chk("r_pc1",    64'(r_pc1),    64'(e1.pc));
        chk("r_inst1",  64'(r_inst1),  64'(e1.inst));
        chk("r_pc2",    64'(r_pc2),    64'(e2.pc));
        chk("r_inst2",  64'(r_inst2),  64'(e2.inst));
        chk("count",    64'(count),    64'(sb.size()));
        chk("full",     64'(full),     64'(sb.size() > DEPTH - 2));
        chk("empty",    64'(empty),    64'(sb.size() == 0));
        nw = (sb.size() > DEPTH - 2) ? 0 : int'(we1) + int'(we1 & we2);
        np = st ? 0 : int'(re1 & ev1) + int'(re1 & re2 & ev2);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (nw >= 1) sb.push_back({p1, inst_of(p1)});
            if (nw == 2) sb.push_back({p2, inst_of(p2)});
            repeat (np) void'(sb.pop_front());
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pcn;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid1", 64'(r_valid1), 64'd0);
        chk("rst_pc1", 64'(r_pc1), 64'd0);
        rst = 1'b0;
        idle();

        // Fill with pairs until full, then one dropped push
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b1, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h1040, 32'h1044, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Drain in order, two per cycle
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();

        // Steady state push 2 / pop 2 across pointer wrap
        pcn = 32'h3000;
        step(1'b1, 1'b1, pcn, pcn + 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        pcn += 32'h8;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, pcn, pcn + 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
            pcn += 32'h8;
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Stall blocks pops but not pushes
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h4000, 32'h4004, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h4008, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h400C, 32'h4010, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h4014, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush wins over a simultaneous push and pop
        step(1'b1, 1'b1, 32'h4018, 32'h401C, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();

        // Push into an empty queue while popping one
        step(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Mixed random traffic
        pcn = 32'h8000;
        for (int k = 0; k < 80; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pcn, pcn + 32'h4,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            pcn += 32'h8;
        end

        // Asynchronous reset mid-stream
        step(1'b1, 1'b1, 32'h5000, 32'h5004, 1'b0, 1'b0, 1'b0, 1'b0);
        w_ena1 = 1'b0; w_ena2 = 1'b0; r_ena1 = 1'b0; r_ena2 = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_valid1", 64'(r_valid1), 64'd0);
        chk("arst_pc1", 64'(r_pc1), 64'd0);
        chk("arst_inst2", 64'(r_inst2), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
